// File: rtl/ram4k_arbiter_pkg.sv
// Shared definitions for the ram4k arbiter: RAM geometry, port ids and the
// lock-owner record used by the arbiter and its picker.
package ram4k_arbiter_pkg;

  localparam int RAM_ADDR_W = 12;
  localparam int RAM_DATA_W = 16;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef struct packed {
    logic valid;
    logic id;
  } owner_t;

  localparam owner_t OWNER_NONE = '{valid: 1'b0, id: 1'b0};

  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way winner selection: a locking owner keeps the port while allowed,
// otherwise round-robin on a tie, otherwise the lone requester.
module rr_pick2
  import ram4k_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  owner_t     owner,
  input  logic       keep,
  output logic [1:0] gnt
);

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    gnt = 2'b00;
    if (owner.valid && req[owner.id] && keep)
      gnt = port_onehot(owner.id);
    else if (&req)
      gnt = port_onehot(~last);
    else
      gnt = req;
  end

endmodule

// File: rtl/ram4k_arbiter.sv
// Arbitrates CPU (port 0) and loader/DMA (port 1) onto one single-port ram4k,
// with registered read data and a bounded burst lock.
module ram4k_arbiter
  import ram4k_arbiter_pkg::*;
#(
  parameter int ADDR_W   = RAM_ADDR_W,
  parameter int DATA_W   = RAM_DATA_W,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  logic [1:0] req, we, lock;
  assign req  = {req1, req0};
  assign we   = {we1, we0};
  assign lock = {lock1, lock0};

  owner_t            owner_q, owner_d;
  logic              last_q, last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  // Owner may stay while under its hold budget, or indefinitely if the other port is idle.
  logic keep;
  assign keep = lock[owner_q.id] & ((hold_q < HOLD_MAX) | ~req[~owner_q.id]);

  logic [1:0] pick, gnt;
  rr_pick2 u_pick (
    .req   (req),
    .last  (last_q),
    .owner (owner_q),
    .keep  (keep),
    .gnt   (pick)
  );

  assign gnt     = rst_n ? pick : 2'b00;
  assign gnt0    = gnt[0];
  assign gnt1    = gnt[1];

  logic granted, win;
  assign granted = |gnt;
  assign win     = gnt[1];

  always_comb begin
    ram_address = '0;
    ram_in      = '0;
    ram_load    = 1'b0;
    if (granted) begin
      ram_address = win ? addr1  : addr0;
      ram_in      = win ? wdata1 : wdata0;
      ram_load    = we[win];
    end
  end

  always_comb begin
    owner_d  = owner_q;
    hold_d   = hold_q;
    last_d   = last_q;
    rvalid_d = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (granted) begin
      last_d = win;
      if (!we[win]) begin
        rvalid_d[win] = 1'b1;
        if (win) rdata1_d = ram_out;
        else     rdata0_d = ram_out;
      end
      if (lock[win]) begin
        owner_d = '{valid: 1'b1, id: win};
        if (owner_q.valid && owner_q.id == win)
          hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_W'(1);
        else
          hold_d = HOLD_W'(1);
      end else begin
        owner_d = OWNER_NONE;
        hold_d  = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q  <= OWNER_NONE;
      last_q   <= PORT_DMA;
      hold_q   <= '0;
      rvalid_q <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      owner_q  <= owner_d;
      last_q   <= last_d;
      hold_q   <= hold_d;
      rvalid_q <= rvalid_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign rvalid0 = rvalid_q[0];
  assign rvalid1 = rvalid_q[1];
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule
